// File: rtl/data_cache_if.sv
// data_cache_if
//   Memory-side bus of the data cache.
//   master (cache side): drives mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb;
//                        receives mem_gnt, mem_rvalid, mem_rdata.
//   slave (memory side): the mirror image.
interface data_cache_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                   input  mem_gnt, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                   output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-through, no-write-allocate data cache with 4-word
//   lines refilled by bursts, and a posted write buffer for stores.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     cpu_addr/r_en/w_en/wdata  MEM-stage request (w_en unshifted, data right-aligned)
//     cpu_rdata, cpu_ready  full aligned load word, request completes this cycle
//     wb_full               write buffer full
//     mem                   memory bus (registered request side)
module data_cache #(
   parameter int unsigned LINES    = 16,
   parameter int unsigned WB_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  cpu_addr,
   input  logic         cpu_r_en,
   input  logic [3:0]   cpu_w_en,
   input  logic [31:0]  cpu_wdata,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_ready,
   output logic         wb_full,
   data_cache_if.master mem
);
   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned TW = 28 - IW;
   localparam int unsigned PW = $clog2(WB_DEPTH);

   typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_DATA} state_t;
   state_t state, state_d;

   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES][4];
   logic [1:0]       beat;

   logic [PW:0]      wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
   logic [29:0]      wb_addr [WB_DEPTH];
   logic [31:0]      wb_data [WB_DEPTH];
   logic [3:0]       wb_strb [WB_DEPTH];

   logic [1:0]       a_word;
   logic [IW-1:0]    a_idx;
   logic [TW-1:0]    a_tag;
   logic             is_store, is_load, hit, push, pop, bypass, fill_beat;
   logic [3:0]       st_strb;
   logic [31:0]      st_data;
   logic [29:0]      head_addr;
   logic [31:0]      head_data;
   logic [3:0]       head_strb;
   logic             req_d, we_d;
   logic [31:0]      addr_d, wdata_d;
   logic [3:0]       strb_d;

   assign a_word   = cpu_addr[3:2];
   assign a_idx    = cpu_addr[4 +: IW];
   assign a_tag    = cpu_addr[31 -: TW];
   assign is_store = |cpu_w_en;
   assign is_load  = cpu_r_en && !is_store;
   assign hit      = valid[a_idx] && (tag_q[a_idx] == a_tag);
   assign st_strb  = cpu_w_en << cpu_addr[1:0];
   assign st_data  = cpu_wdata << {cpu_addr[1:0], 3'b000};

   assign wb_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   // The bus registers always show the head entry, so a grant on a write pops it.
   assign pop      = mem.mem_req && mem.mem_we && mem.mem_gnt;
   assign push     = (state == IDLE) && is_store && (!wb_full || pop);
   assign wr_ptr_d = wr_ptr + {{PW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr + {{PW{1'b0}}, pop};
   assign fill_beat = (state == RD_DATA) && mem.mem_rvalid;

   // A store into an empty buffer becomes the head before the array is written.
   assign bypass    = push && (rd_ptr_d == wr_ptr);
   assign head_addr = bypass ? cpu_addr[31:2] : wb_addr[rd_ptr_d[PW-1:0]];
   assign head_data = bypass ? st_data        : wb_data[rd_ptr_d[PW-1:0]];
   assign head_strb = bypass ? st_strb        : wb_strb[rd_ptr_d[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d   = state;
      cpu_ready = 1'b1;
      cpu_rdata = '0;
      unique case (state)
         IDLE: begin
            if (is_store) begin
               cpu_ready = push;
            end else if (is_load) begin
               cpu_ready = hit;
               if (hit) cpu_rdata = data_q[a_idx][a_word];
               else     state_d   = (rd_ptr_d == wr_ptr_d) ? RD_REQ : DRAIN;
            end
         end
         DRAIN: begin
            cpu_ready = !(is_store || is_load);
            if (rd_ptr_d == wr_ptr_d) state_d = RD_REQ;
         end
         RD_REQ: begin
            cpu_ready = !(is_store || is_load);
            if (mem.mem_gnt) state_d = RD_DATA;
         end
         RD_DATA: begin
            cpu_ready = !(is_store || is_load);
            if (fill_beat && beat == 2'd3) state_d = IDLE;
         end
      endcase
      if (!rst_n) begin
         cpu_ready = 1'b1;
         cpu_rdata = '0;
      end

      // Bus outputs are a registered function of the post-edge state, which
      // keeps them stable while a request waits for its grant.
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      strb_d  = '0;
      if (state_d == RD_REQ) begin
         req_d  = 1'b1;
         addr_d = {cpu_addr[31:4], 4'b0000};
      end else if ((state_d == IDLE || state_d == DRAIN) && (rd_ptr_d != wr_ptr_d)) begin
         req_d   = 1'b1;
         we_d    = 1'b1;
         addr_d  = {head_addr, 2'b00};
         wdata_d = head_data;
         strb_d  = head_strb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid         <= '0;
         beat          <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_wstrb <= '0;
      end else begin
         wr_ptr        <= wr_ptr_d;
         rd_ptr        <= rd_ptr_d;
         mem.mem_req   <= req_d;
         mem.mem_we    <= we_d;
         mem.mem_addr  <= addr_d;
         mem.mem_wdata <= wdata_d;
         mem.mem_wstrb <= strb_d;
         // The line is overwritten beat by beat, so it is invalid until beat 3.
         if (state == IDLE && is_load && !hit) valid[a_idx] <= 1'b0;
         if (fill_beat) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) valid[a_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         wb_addr[wr_ptr[PW-1:0]] <= cpu_addr[31:2];
         wb_data[wr_ptr[PW-1:0]] <= st_data;
         wb_strb[wr_ptr[PW-1:0]] <= st_strb;
         if (hit) begin
            for (int unsigned b = 0; b < 4; b++)
               if (st_strb[b]) data_q[a_idx][a_word][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
      if (fill_beat) begin
         data_q[a_idx][beat] <= mem.mem_rdata;
         if (beat == 2'd3) tag_q[a_idx] <= a_tag;
      end
   end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Randomised and directed bench for data_cache. A reference model holds the
//   CPU-visible memory, the external memory and the cached line tags; expected
//   load data, bus writes and line reads are queued at issue time and checked
//   by independent monitors on the CPU and memory sides.
`timescale 1ns/1ps
module tb_data_cache;
   localparam int unsigned LINES    = 16;
   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned IW       = $clog2(LINES);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_r_en = 1'b0;
   logic [3:0]  cpu_w_en = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        wb_full;

   data_cache_if bus ();

   data_cache #(.LINES(LINES), .WB_DEPTH(WB_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_en(cpu_w_en), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .wb_full(wb_full),
      .mem(bus.master)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      bit [31:0] addr;
      bit [31:0] data;
      bit [3:0]  strb;
   } wr_t;

   bit [31:0]   arch [bit [29:0]];
   bit [31:0]   extm [bit [29:0]];
   bit          ref_valid [LINES];
   int unsigned ref_tag   [LINES];
   bit [31:0]   ld_q [$];
   bit [31:0]   rd_q [$];
   wr_t         wr_q [$];

   function automatic bit [31:0] init_word(bit [29:0] w);
      bit [31:0] ba = {w, 2'b00};
      if (ba >= 32'h100 && ba < 32'h110) return 32'h11 * (32'(ba[3:2]) + 32'd1);
      return ({2'b00, w} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit [31:0] arch_rd(bit [29:0] w);
      return arch.exists(w) ? arch[w] : init_word(w);
   endfunction

   function automatic bit [31:0] extm_rd(bit [29:0] w);
      return extm.exists(w) ? extm[w] : init_word(w);
   endfunction

   // ---------------- memory responder / bus monitor ----------------
   bit gnt_on = 1'b1;
   int gnt_pct = 100;
   int rv_pct = 100;
   bit arm_gnt = 1'b0;
   int first_gnt_cyc = -1;
   int beats_taken = 0;

   initial begin
      bit        s_req, s_we, s_gnt, s_rv;
      bit [31:0] s_addr, s_wdata, w;
      bit [3:0]  s_strb;
      int        s_cyc;
      bit [31:0] burst [$];
      wr_t       e;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         s_req = bus.mem_req;  s_we = bus.mem_we;  s_gnt = bus.mem_gnt;  s_rv = bus.mem_rvalid;
         s_addr = bus.mem_addr;  s_wdata = bus.mem_wdata;  s_strb = bus.mem_wstrb;  s_cyc = cyc;
         @(posedge clk);
         if (!rst_n) begin
            burst.delete();
         end else begin
            if (s_rv && burst.size() > 0) begin
               void'(burst.pop_front());
               beats_taken++;
            end
            if (s_req && s_gnt) begin
               if (s_we) begin
                  if (arm_gnt) begin
                     first_gnt_cyc = s_cyc;
                     arm_gnt = 1'b0;
                  end
                  w = extm_rd(s_addr[31:2]);
                  for (int b = 0; b < 4; b++)
                     if (s_strb[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
                  extm[s_addr[31:2]] = w;
                  if (wr_q.size() == 0) begin
                     fail("bus write", $sformatf("unexpected write at %h", s_addr));
                  end else begin
                     e = wr_q.pop_front();
                     check("write addr", s_addr, e.addr);
                     check("write data", s_wdata, e.data);
                     check("write strb", {28'd0, s_strb}, {28'd0, e.strb});
                  end
               end else begin
                  check("writes before read", wr_q.size(), 0);
                  if (rd_q.size() == 0) fail("bus read", $sformatf("unexpected read at %h", s_addr));
                  else check("read addr", s_addr, rd_q.pop_front());
                  for (int k = 0; k < 4; k++) burst.push_back(extm_rd(s_addr[31:2] + 30'(k)));
                  beats_taken = 0;
               end
            end
         end
         #1;
         bus.mem_gnt = gnt_on && rst_n && ($urandom_range(99) < gnt_pct);
         if (rst_n && burst.size() > 0 && $urandom_range(99) < rv_pct) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = burst[0];
         end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
         end
      end
   end

   // ---------------- CPU-side monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && cpu_r_en && cpu_w_en == 4'b0 && cpu_ready) begin
            if (ld_q.size() == 0) fail("load data", "no expected load queued");
            else check("load data", cpu_rdata, ld_q.pop_front());
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue_load(input bit [31:0] a, output int lat);
      int unsigned idx = (a >> 4) % LINES;
      int unsigned tg  = a >> (4 + IW);
      ld_q.push_back(arch_rd(a[31:2]));
      if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
         rd_q.push_back({a[31:4], 4'b0000});
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
      end
      cpu_addr = a;  cpu_r_en = 1'b1;  cpu_w_en = '0;
      lat = 0;
      @(negedge clk);
      while (!cpu_ready && lat < 300) begin
         lat++;
         @(negedge clk);
      end
      if (!cpu_ready) fail("load timeout", $sformatf("no cpu_ready for load at %h", a));
      @(posedge clk);
      #1 cpu_r_en = 1'b0;
   endtask

   task automatic issue_store(input bit [31:0] a, input bit [3:0] we, input bit [31:0] d,
                              output int lat, output int acc_cyc);
      wr_t e;
      bit [31:0] w;
      e.addr = {a[31:2], 2'b00};
      e.strb = we << a[1:0];
      e.data = d << (8 * a[1:0]);
      w = arch_rd(a[31:2]);
      for (int b = 0; b < 4; b++)
         if (e.strb[b]) w[8*b +: 8] = e.data[8*b +: 8];
      arch[a[31:2]] = w;
      wr_q.push_back(e);
      cpu_addr = a;  cpu_w_en = we;  cpu_wdata = d;  cpu_r_en = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!cpu_ready && lat < 300) begin
         lat++;
         @(negedge clk);
      end
      if (!cpu_ready) fail("store timeout", $sformatf("no cpu_ready for store at %h", a));
      acc_cyc = cyc;
      @(posedge clk);
      #1 cpu_w_en = '0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int        lat, acc, n;
      bit [31:0] a, d;
      int unsigned sz, off;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset cpu_ready", cpu_ready, 1);
      check("reset cpu_rdata", cpu_rdata, 0);
      check("reset wb_full", wb_full, 0);
      check("reset mem_req", bus.mem_req, 0);
      check("reset mem_we", bus.mem_we, 0);
      check("reset mem_addr", bus.mem_addr, 0);
      check("reset mem_wdata", bus.mem_wdata, 0);
      check("reset mem_wstrb", {28'd0, bus.mem_wstrb}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle(2);

      // cold miss then same-line hit
      issue_load(32'h0000_0104, lat);  check("cold miss latency", lat, 6);
      issue_load(32'h0000_010C, lat);  check("hit latency", lat, 0);

      // byte store into the cached line
      issue_store(32'h0000_0106, 4'b0001, 32'h0000_00AB, lat, acc);  check("sb no stall", lat, 0);
      issue_load(32'h0000_0104, lat);  check("sb merge hit latency", lat, 0);

      // store miss does not allocate
      issue_store(32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, lat, acc);
      issue_load(32'h0000_0100, lat);  check("store miss kept line", lat, 0);
      issue_load(32'h0000_2000, lat);  check("load after store miss refills", lat > 0, 1);

      // fill the write buffer with the bus stalled
      settle(10);
      gnt_on = 1'b0;
      settle(1);
      for (int i = 0; i < 4; i++) begin
         issue_store(32'h0000_3000 + 32'(4 * i), 4'b1111, $urandom, lat, acc);
         check("sw into buffer no stall", lat, 0);
      end
      @(negedge clk);
      check("wb_full after four", wb_full, 1);
      @(posedge clk);
      #1 arm_gnt = 1'b1;
      fork
         issue_store(32'h0000_3010, 4'b1111, $urandom, lat, acc);
         begin
            repeat (3) @(posedge clk);
            #2 gnt_on = 1'b1;
         end
      join
      check("fifth store stalled", lat > 0, 1);
      check("fifth accepted with first grant", acc, first_gnt_cyc);
      settle(10);

      // load miss behind two buffered stores
      gnt_on = 1'b0;
      settle(1);
      issue_store(32'h0000_4044, 4'b1111, 32'h1234_5678, lat, acc);
      issue_store(32'h0000_5122, 4'b0011, 32'h0000_BEEF, lat, acc);
      fork
         issue_load(32'h0000_4040, lat);
         begin
            repeat (4) @(posedge clk);
            #2 gnt_on = 1'b1;
         end
      join
      issue_load(32'h0000_4044, lat);  check("drained store visible", lat, 0);
      settle(5);

      // reset during beat 2 of a refill
      rd_q.push_back(32'h0000_5000);
      cpu_addr = 32'h0000_5000;
      cpu_r_en = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.mem_rvalid && beats_taken == 2) && n < 100);
      if (n >= 100) fail("reach beat 2", "refill beat 2 never presented");
      rst_n = 1'b0;
      cpu_r_en = 1'b0;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      @(negedge clk);
      check("mid-refill reset cpu_ready", cpu_ready, 1);
      check("mid-refill reset mem_req", bus.mem_req, 0);
      check("mid-refill reset wb_full", wb_full, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle(2);
      issue_load(32'h0000_5000, lat);  check("reload after reset latency", lat, 6);
      issue_load(32'h0000_0104, lat);  check("all lines invalid after reset", lat, 6);

      // randomised traffic over a few aliasing lines
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) begin
            gnt_pct = $urandom_range(100, 30);
            rv_pct  = $urandom_range(100, 40);
         end
         a = ($urandom_range(2) << (4 + IW)) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2);
         if ($urandom_range(1) == 0) begin
            issue_load(a | 32'($urandom_range(3)), lat);
         end else begin
            sz = $urandom_range(2);
            d  = $urandom;
            if (sz == 0) begin
               off = $urandom_range(3);
               issue_store(a | off, 4'b0001, d & 32'h0000_00FF, lat, acc);
            end else if (sz == 1) begin
               off = 2 * $urandom_range(1);
               issue_store(a | off, 4'b0011, d & 32'h0000_FFFF, lat, acc);
            end else begin
               issue_store(a, 4'b1111, d, lat, acc);
            end
         end
         if ($urandom_range(3) == 0) settle(1);
      end

      gnt_pct = 100;
      rv_pct  = 100;
      settle(40);
      check("loads outstanding", ld_q.size(), 0);
      check("reads outstanding", rd_q.size(), 0);
      check("writes outstanding", wr_q.size(), 0);
      foreach (arch[k]) check($sformatf("memory word %h", {k, 2'b00}), extm_rd(k), arch[k]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end
endmodule
